// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response bundle for mem_access_unit.
// Latency: none, this is only wiring between the pipeline and the unit.
// Backpressure: req_ready gates acceptance; rsp_valid is a pulse with no ready.
// Ports: req_valid/req_ready handshake, req_we/size/unsigned/addr/wdata request
//        fields, rsp_valid/rsp_rdata/rsp_err response.
// Modports: master = pipeline (drives requests), slave = mem_access_unit.
interface mem_access_unit_if #(
  parameter int RAM_ADDR_BITS = 10
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [1:0]               req_size;
  logic                     req_unsigned;
  logic [RAM_ADDR_BITS+1:0] req_addr;
  logic [31:0]              req_wdata;
  logic                     rsp_valid;
  logic [31:0]              rsp_rdata;
  logic                     rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage front end for a single-port sync RAM without byte enables; sub-word stores use read-modify-write.
// Latency (accept edge = cycle 0, rsp_valid cycle): error 1, word store 2, load 3, sub-word store 4.
// Backpressure: req_ready only in IDLE, one request in flight; responses are pulses with no backpressure.
// Ports: clk, rst_n (async active-low); req_if (slave modport: request/response);
//        mem_write/mem_addr/mem_wdata to the RAM, mem_rdata from it (registered, one cycle after the address);
//        load_count/store_count performance counters.
// Optional: define MEM_ACCESS_PERF_CNT_EN to build the saturating 16-bit load/store counters;
//           otherwise both count outputs are tied to zero.
module mem_access_unit #(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mem_access_unit_if.slave         req_if,
  output logic                     mem_write,
  output logic [RAM_ADDR_BITS-1:0] mem_addr,
  output logic [RAM_WIDTH-1:0]     mem_wdata,
  input  logic [RAM_WIDTH-1:0]     mem_rdata,
  output logic [15:0]              load_count,
  output logic [15:0]              store_count
);

  typedef enum logic [2:0] {IDLE, RD, LD_CAP, RMW_MRG, WR, RESP} state_t;

  state_t                   state_q, state_d;
  logic                     accept;
  logic                     misaligned;
  logic [RAM_ADDR_BITS+1:0] addr_q;
  logic [1:0]               size_q;
  logic                     we_q;
  logic                     uns_q;
  logic [15:0]              wdata_q;   // only sub-word stores need the latched data
  logic [RAM_WIDTH-1:0]     rdata_q;
  logic                     err_q;
  logic [RAM_WIDTH-1:0]     mwdata_q;
  logic [7:0]               lane_b;
  logic [15:0]              lane_h;
  logic [RAM_WIDTH-1:0]     ld_data;
  logic [RAM_WIDTH-1:0]     merged;

  assign accept = (state_q == IDLE) && req_if.req_valid;

  always_comb begin
    misaligned = 1'b0;
    case (req_if.req_size)
      2'b01:   misaligned = req_if.req_addr[0];
      2'b10:   misaligned = |req_if.req_addr[1:0];
      2'b11:   misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // mem_write is decoded from state so it drops the instant reset asserts.
  always_comb begin
    state_d          = state_q;
    req_if.req_ready = 1'b0;
    req_if.rsp_valid = 1'b0;
    mem_write        = 1'b0;
    case (state_q)
      IDLE: begin
        req_if.req_ready = 1'b1;
        if (req_if.req_valid) begin
          if (misaligned)                    state_d = RESP;
          else if (!req_if.req_we)           state_d = RD;
          else if (req_if.req_size == 2'b10) state_d = WR;
          else                               state_d = RD;
        end
      end
      RD:      state_d = we_q ? RMW_MRG : LD_CAP;
      LD_CAP:  state_d = RESP;
      RMW_MRG: state_d = WR;
      WR: begin
        mem_write = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        req_if.rsp_valid = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Lane extraction for loads and lane replacement for read-modify-write.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   lane_b = mem_rdata[7:0];
      2'b01:   lane_b = mem_rdata[15:8];
      2'b10:   lane_b = mem_rdata[23:16];
      default: lane_b = mem_rdata[31:24];
    endcase
    lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (size_q)
      2'b00:   ld_data = {{24{~uns_q & lane_b[7]}}, lane_b};
      2'b01:   ld_data = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: ld_data = mem_rdata;
    endcase

    merged = mem_rdata;
    if (size_q == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
    else                 merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      size_q   <= '0;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      mwdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_if.req_addr;
        size_q  <= req_if.req_size;
        we_q    <= req_if.req_we;
        uns_q   <= req_if.req_unsigned;
        wdata_q <= req_if.req_wdata[15:0];
        // Previous response is held until here, then cleared.
        rdata_q <= '0;
        err_q   <= misaligned;
        if (req_if.req_we && (req_if.req_size == 2'b10) && !misaligned)
          mwdata_q <= req_if.req_wdata;
      end
      if (state_q == LD_CAP)  rdata_q  <= ld_data;
      if (state_q == RMW_MRG) mwdata_q <= merged;
    end
  end

  assign mem_addr         = addr_q[RAM_ADDR_BITS+1:2];
  assign mem_wdata        = mwdata_q;
  assign req_if.rsp_rdata = rdata_q;
  assign req_if.rsp_err   = err_q;

`ifdef MEM_ACCESS_PERF_CNT_EN
  logic [15:0] ld_cnt_q;
  logic [15:0] st_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      if ((state_q == RESP) && !we_q && !err_q && (ld_cnt_q != 16'hFFFF))
        ld_cnt_q <= ld_cnt_q + 16'd1;
      if ((state_q == WR) && (st_cnt_q != 16'hFFFF))
        st_cnt_q <= st_cnt_q + 16'd1;
    end
  end

  assign load_count  = ld_cnt_q;
  assign store_count = st_cnt_q;
`else
  assign load_count  = 16'd0;
  assign store_count = 16'd0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed test-plan sequence, then randomized traffic.
// A byte-level shadow memory predicts every response, RAM write and counter value.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        mem_write;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [15:0] load_count;
  logic [15:0] store_count;

  mem_access_unit_if #(.RAM_ADDR_BITS(10)) bus ();

  mem_access_unit #(.RAM_WIDTH(32), .RAM_ADDR_BITS(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_if      (bus),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .load_count  (load_count),
    .store_count (store_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached single-port synchronous RAM (read-first, registered output).
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (mem_write) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    int          lat;
    int          wr_cyc;
    int          rd_cyc;
    logic [9:0]  waddr;
    logic [31:0] wdat;
    logic [31:0] rdata;
    logic        err;
    logic        we;
    logic        lit_en;
    logic [31:0] lit;
    logic        cnt_lit_en;
    int          ld_lit;
    int          st_lit;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mdl [0:1023];
  int          n_chk;
  int          n_fail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference behaviour: byte-by-byte view of little-endian memory.
  task automatic predict(input logic we, input logic [1:0] size, input logic uns,
                         input logic [11:0] addr, input logic [31:0] wdata, output exp_t e);
    int          nb;
    int          off;
    logic [31:0] old;
    logic [31:0] v;
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off = int'(addr[1:0]);
    e = '{default: 0};
    e.we    = we;
    e.waddr = addr[11:2];
    e.err   = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    old = mdl[addr[11:2]];
    v   = 32'd0;
    if (e.err) begin
      e.lat = 1;
    end else if (!we) begin
      e.lat    = 3;
      e.rd_cyc = 1;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = old[8*(off+i) +: 8];
      if (!uns && v[8*nb-1])
        for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
      e.rdata = v;
    end else begin
      e.lat    = (nb == 4) ? 2 : 4;
      e.wr_cyc = e.lat - 1;
      e.rd_cyc = (nb == 4) ? 0 : 1;
      v = old;
      for (int i = 0; i < nb; i++) v[8*(off+i) +: 8] = wdata[8*i +: 8];
      e.wdat = v;
      mdl[addr[11:2]] = v;
    end
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [11:0] addr, input logic [31:0] wdata);
    @(posedge clk);
    #1;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
  endtask

  task automatic scramble_req();
    logic [31:0] r;
    r = $urandom;
    bus.req_valid    = 1'b0;
    bus.req_we       = r[0];
    bus.req_size     = r[2:1];
    bus.req_unsigned = r[3];
    bus.req_addr     = r[15:4];
    bus.req_wdata    = $urandom;
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [11:0] addr, input logic [31:0] wdata,
                        input logic lit_en, input logic [31:0] lit,
                        input logic cnt_en, input int ld_lit, input int st_lit);
    exp_t e;
    int   t;
    predict(we, size, uns, addr, wdata, e);
    e.lit_en     = lit_en;
    e.lit        = lit;
    e.cnt_lit_en = cnt_en;
    e.ld_lit     = ld_lit;
    e.st_lit     = st_lit;
    drive_req(we, size, uns, addr, wdata);
    @(posedge clk);
    q.push_back(e);
    #1;
    scramble_req();
    t = 0;
    while (q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      $display("FAIL wait_rsp: got no completion after %0d cycles, expected %0d", t, e.lat);
      $fatal(1, "response timeout");
    end
  endtask

  // Single compare process: every negedge (and on reset assertion) checks all outputs.
  exp_t        cur;
  int          cyc;
  logic [31:0] hold_rdata;
  logic        hold_err;
  logic [31:0] seen_wdat;
  int          m_ld;
  int          m_st;
  logic        cnt_pend;
  int          cnt_ld_lit;
  int          cnt_st_lit;

  initial begin
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_load_count", {16'd0, load_count}, 32'd0);
        chk("rst_store_count", {16'd0, store_count}, 32'd0);
        cyc = 0; hold_rdata = 32'd0; hold_err = 1'b0;
        m_ld = 0; m_st = 0; cnt_pend = 1'b0;
        q.delete();
      end else if (q.size() != 0) begin
        cyc++;
        cur = q[0];
        chk("busy_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("mem_write", {31'd0, mem_write}, {31'd0, cyc == cur.wr_cyc});
        if (cyc == cur.wr_cyc) begin
          chk("wr_mem_addr", {22'd0, mem_addr}, {22'd0, cur.waddr});
          chk("wr_mem_wdata", mem_wdata, cur.wdat);
          seen_wdat = mem_wdata;
          m_st++;
        end
        if (cyc == cur.rd_cyc)
          chk("rd_mem_addr", {22'd0, mem_addr}, {22'd0, cur.waddr});
        chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, cyc == cur.lat});
        if (cyc >= cur.lat) begin
          chk("rsp_rdata", bus.rsp_rdata, cur.rdata);
          chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, cur.err});
          if (cur.lit_en) begin
            chk("model_literal", (cur.we && !cur.err) ? cur.wdat : cur.rdata, cur.lit);
            chk("dut_literal", (cur.we && !cur.err) ? seen_wdat : bus.rsp_rdata, cur.lit);
          end
          if (!cur.we && !cur.err) m_ld++;
          if (cur.cnt_lit_en) begin
            cnt_pend   = 1'b1;
            cnt_ld_lit = cur.ld_lit;
            cnt_st_lit = cur.st_lit;
          end
          hold_rdata = cur.rdata;
          hold_err   = cur.err;
          cyc = 0;
          void'(q.pop_front());
        end else begin
          chk("pending_rsp_rdata", bus.rsp_rdata, 32'd0);
          chk("pending_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        end
      end else begin
        chk("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("idle_mem_write", {31'd0, mem_write}, 32'd0);
        chk("idle_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("hold_rsp_rdata", bus.rsp_rdata, hold_rdata);
        chk("hold_rsp_err", {31'd0, bus.rsp_err}, {31'd0, hold_err});
`ifdef MEM_ACCESS_PERF_CNT_EN
        chk("load_count", {16'd0, load_count}, m_ld);
        chk("store_count", {16'd0, store_count}, m_st);
        if (cnt_pend) begin
          chk("model_load_count", m_ld, cnt_ld_lit);
          chk("model_store_count", m_st, cnt_st_lit);
          chk("lit_load_count", {16'd0, load_count}, cnt_ld_lit);
          chk("lit_store_count", {16'd0, store_count}, cnt_st_lit);
          cnt_pend = 1'b0;
        end
`else
        chk("load_count", {16'd0, load_count}, 32'd0);
        chk("store_count", {16'd0, store_count}, 32'd0);
        cnt_pend = 1'b0;
`endif
      end
    end
  end

  // Sub-word store interrupted by reset during its merge cycle; the RAM must keep the old word.
  task automatic reset_during_rmw(input logic [11:0] addr, input logic [31:0] wdata);
    exp_t        e;
    logic [31:0] saved;
    saved = mdl[addr[11:2]];
    predict(1'b1, 2'd0, 1'b0, addr, wdata, e);
    mdl[addr[11:2]] = saved;
    drive_req(1'b1, 2'd0, 1'b0, addr, wdata);
    @(posedge clk);
    q.push_back(e);
    #1;
    scramble_req();
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    logic [1:0]  sz;
    for (int i = 0; i < 1024; i++) begin
      ram[i] = 32'd0;
      mdl[i] = 32'd0;
    end
    mem_rdata = 32'd0;
    n_chk = 0;
    n_fail = 0;
    scramble_req();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    do_req(1'b1, 2'd2, 1'b0, 12'h014, 32'h8899AABB, 1'b1, 32'h8899AABB, 1'b0, 0, 0);
    do_req(1'b0, 2'd2, 1'b0, 12'h014, 32'h0,        1'b1, 32'h8899AABB, 1'b0, 0, 0);
    do_req(1'b0, 2'd0, 1'b0, 12'h016, 32'h0,        1'b1, 32'hFFFFFF99, 1'b0, 0, 0);
    do_req(1'b0, 2'd0, 1'b1, 12'h016, 32'h0,        1'b1, 32'h00000099, 1'b0, 0, 0);
    do_req(1'b0, 2'd1, 1'b0, 12'h016, 32'h0,        1'b1, 32'hFFFF8899, 1'b0, 0, 0);
    do_req(1'b1, 2'd1, 1'b0, 12'h016, 32'hFFFF1234, 1'b1, 32'h1234AABB, 1'b0, 0, 0);
    do_req(1'b0, 2'd2, 1'b0, 12'h014, 32'h0,        1'b1, 32'h1234AABB, 1'b0, 0, 0);
    do_req(1'b0, 2'd2, 1'b0, 12'h015, 32'h0,        1'b1, 32'h0,        1'b0, 0, 0);
    do_req(1'b1, 2'd1, 1'b0, 12'h013, 32'hDEAD,     1'b1, 32'h0,        1'b0, 0, 0);
    do_req(1'b0, 2'd3, 1'b0, 12'h014, 32'h0,        1'b1, 32'h0,        1'b0, 0, 0);

    reset_during_rmw(12'h014, 32'h00000055);

    // After reset: 3 loads, 2 stores, 1 misaligned load.
    do_req(1'b0, 2'd2, 1'b0, 12'h014, 32'h0,        1'b1, 32'h1234AABB, 1'b0, 0, 0);
    do_req(1'b0, 2'd0, 1'b1, 12'h015, 32'h0,        1'b1, 32'h000000AA, 1'b0, 0, 0);
    do_req(1'b0, 2'd1, 1'b0, 12'h016, 32'h0,        1'b1, 32'h00001234, 1'b0, 0, 0);
    do_req(1'b1, 2'd2, 1'b0, 12'h020, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 1'b0, 0, 0);
    do_req(1'b1, 2'd0, 1'b0, 12'h021, 32'h0000005A, 1'b1, 32'hCAFE5A0D, 1'b0, 0, 0);
    do_req(1'b0, 2'd2, 1'b0, 12'h022, 32'h0,        1'b1, 32'h0,        1'b1, 3, 2);

    for (int n = 0; n < 300; n++) begin
      r = $urandom;
      a = (r[3:2] == 2'd0) ? $urandom : {26'd0, r[9:4]};
      case (r[13:10])
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4: sz = 2'd0;
        4'd5, 4'd6, 4'd7, 4'd8, 4'd9: sz = 2'd1;
        4'd15:                        sz = 2'd3;
        default:                      sz = 2'd2;
      endcase
      if (r[16:14] != 3'd0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'd0;
      end
      do_req(r[0], sz, r[1], a[11:0], $urandom, 1'b0, 32'h0, 1'b0, 0, 0);
      repeat (r[18:17] == 2'd3 ? 2 : 0) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Requester-side front end for the single-port synchronous data memory in the MEM pipeline stage.
- Accepts byte, halfword and word loads/stores from the pipeline on a byte address.
- Drives the RAM's write/address/data pins and consumes its registered read data, with sign/zero extension on loads.
- The RAM has no byte enables, so sub-word stores are performed as read-modify-write.

Parameters:
- RAM_WIDTH, 32: data width; fixed at 32, other values unsupported.
- RAM_ADDR_BITS, 10: word-address width of the attached RAM; byte address is RAM_ADDR_BITS+2.

Ports:
- clk  in  1  rising-edge clock, shared with the RAM.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted on a clk edge where req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as a misaligned error.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  RAM_ADDR_BITS+2  byte address, little-endian (byte 0 = bits 7:0).
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle pulse; no backpressure.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  misaligned access, valid with rsp_valid.
- mem_write  out  1  to RAM write.
- mem_addr  out  RAM_ADDR_BITS  to RAM address = latched req_addr[RAM_ADDR_BITS+1:2].
- mem_wdata  out  32  to RAM input data.
- mem_rdata  in  32  from RAM output; valid the cycle after a read is presented.
- load_count  out  16  see Optional Feature.
- store_count  out  16  see Optional Feature.

Behaviour:
- Reset (async, rst_n low): state = IDLE; all outputs 0 except req_ready = 1.
  - mem_write is decoded from state, so it drops in the same instant reset asserts.
  - An interrupted store never reaches the RAM; the RAM word keeps its old value.
- Request latch: address, size, we, unsigned and wdata are latched on the accept edge. The request inputs are don't-care afterwards.
- Misaligned = (half && addr[0]) || (word && addr[1:0] != 0) || size == 11.
- States: IDLE, RD, LD_CAP, RMW_MRG, WR, RESP.
- IDLE, on accept:
  - misaligned → RESP with rsp_err = 1 and no RAM access.
  - load → RD.
  - word store → WR with mem_wdata = wdata.
  - sub-word store → RD.
- RD: mem_write = 0 and mem_addr = word address for exactly one cycle. Next state is LD_CAP for a load, RMW_MRG for a store.
- LD_CAP: sample mem_rdata, select the byte lane (addr[1:0]) or half lane (addr[1]), extend per req_unsigned, register into rsp_rdata → RESP.
- RMW_MRG: replace the addressed lane of mem_rdata with wdata[7:0] or wdata[15:0], register the merged word into mem_wdata → WR.
- WR: mem_write = 1 for exactly one cycle → RESP.
- RESP: rsp_valid = 1 for one cycle, req_ready = 0 → IDLE.
  - rsp_rdata and rsp_err hold until the next accept, then clear to 0.
- Latency, counting the accept edge as cycle 0 (rsp_valid high in the listed cycle):
  - error: cycle 1.
  - word store: cycle 2; mem_write high in cycle 1.
  - load: cycle 3.
  - sub-word store: cycle 4; RD in cycle 1, mem_write high in cycle 3.
- Throughput: the next accept is possible in the cycle after RESP.
- mem_addr holds its last value when idle; mem_write is 0 in every state except WR.

Optional Feature:
- Macro: MEM_ACCESS_PERF_CNT_EN.
- Defined:
  - load_count increments in RESP for non-error loads.
  - store_count increments in WR.
  - Both are 16-bit, saturate at 0xFFFF and are cleared by reset.
- Undefined: both outputs are tied to 0 and no counter flops are synthesized. Functional behaviour is otherwise identical.

Test Plan:
- Word store addr 0x14 data 0x8899AABB, then word load 0x14 → mem_write high in cycle 1 only with mem_addr = 5; load rsp_valid in cycle 3 with rsp_rdata = 0x8899AABB, rsp_err = 0.
- From that state, byte load 0x16: signed → 0xFFFFFF99; unsigned → 0x00000099. Half load 0x16 signed → 0xFFFF8899.
- Half store 0x16 data 0xFFFF1234 → RD in cycle 1, single mem_write in cycle 3 with mem_wdata = 0x1234AABB; a following word load returns 0x1234AABB.
- Word load 0x15, half store 0x13 and size 11 → rsp_valid in cycle 1 with rsp_err = 1, rsp_rdata = 0; mem_write never asserts.
- Byte store 0x14 data 0x55, rst_n pulsed low in cycle 2 (RMW_MRG) → mem_write never asserts, all outputs 0 and req_ready = 1 immediately; the RAM word stays 0x1234AABB.
- With MEM_ACCESS_PERF_CNT_EN: 3 loads, 2 stores and 1 misaligned load → load_count = 3, store_count = 2. Without the macro: both read 0.
